dfx_mbist_en_sync_mc: RTL and testbench
=======================================

Name: dfx_mbist_en_sync_mc

Overview:
Multi-channel MBIST enable synchronizer for the memory array test controller. It carries NUM_CH asynchronous enables into the array clock domain through a configurable-depth synchronizer, with an internal reset synchronizer. Rising enables are released through a staggered sequencer, which limits the current step when many arrays start BIST together. Falling enables take effect immediately.

Parameters:
NUM_CH, 4, number of enable channels (1..32)
SYNC_STAGES, 2, flop depth of the reset and data synchronizers (>=2)
STAGGER_CYC, 8, clk cycles between successive channel grant edges (>=1)
FILT_CYC, 3, stable cycles required by the glitch filter (>=1); used only with DFX_MBIST_EN_SYNC_FILTER_EN

Ports:
clk  input  1  array-domain clock
rst  input  1  reset, asynchronous, active-high
en_in  input  NUM_CH  per-channel MBIST enable, asynchronous to clk
en_out  output  NUM_CH  synchronized, sequenced enable per channel
busy  output  1  high while the stagger gap counter runs
en_all_active  output  1  high when en_out equals all ones

Behaviour:
- Interface: single clock clk; rst asynchronous and active-high.
- Reset synchronizer:
  - rst asserts rst_int immediately.
  - On deassertion, rst_int drops after SYNC_STAGES rising edges of clk, through a chain loaded with constant 1.
  - All flops below reset asynchronously on rst_int.
- Reset values: en_out=0, busy=0, en_all_active=0. Sequencer state is IDLE and the counter is 0.
- Data sync:
  - Each en_in[i] passes through SYNC_STAGES flops to give en_sync[i].
  - No cross-channel coherency is guaranteed.
- pending = en_sync & ~en_out.
- Sequencer, 2 states, counter width $clog2(STAGGER_CYC+1):
  - IDLE, pending!=0: set en_out[k] at the next edge, where k is the lowest-index pending bit. Load cnt=STAGGER_CYC-1. Go to GAP. Exception: if STAGGER_CYC==1, stay in IDLE.
  - IDLE, pending==0: hold.
  - GAP, cnt!=0: decrement cnt.
  - GAP, cnt==0, pending!=0: grant the lowest pending bit, reload cnt, stay in GAP.
  - GAP, cnt==0, pending==0: go to IDLE.
  - Result: grant edges are exactly STAGGER_CYC cycles apart, one channel per grant.
- Disable: en_sync[i]==0 clears en_out[i] at the next edge in any state. Disable never waits for and never resets the gap counter.
- Simultaneous events: a grant of channel k and a clear of channel j!=k in the same cycle are both applied. A channel that drops before its grant is simply never granted.
- Re-enable: a channel that falls and rises again re-enters pending and queues by index.
- busy = (state==GAP), registered from state.
- en_all_active = &en_out, registered. It rises one cycle after the final grant.
- Latency with the sequencer idle: en_in rising sampled at edge 0 gives en_out high after edge SYNC_STAGES+1. Falling edges have the same latency.
- Reset mid-operation: outputs return to 0 asynchronously. After release, nothing is granted until rst_int has deasserted and en_in has re-synchronized.

Optional Feature:
DFX_MBIST_EN_SYNC_FILTER_EN
- Defined:
  - Each channel adds a stability filter after en_sync: a saturating counter up to FILT_CYC and a filtered bit.
  - The filtered bit changes only after en_sync differs from it for FILT_CYC consecutive cycles. A mismatch shorter than that resets the counter.
  - pending and the disable rule use the filtered bit.
  - Latency on both edges grows by FILT_CYC cycles.
- Undefined: the filter logic is absent and the sequencer uses en_sync directly.

Test Plan:
1. Reset/latency: NUM_CH=4, SYNC_STAGES=2. Release rst, wait 2 edges, then set en_in=4'b0001 -> en_out[0] high exactly 3 edges after sampling; busy high for 8 cycles; en_all_active=0.
2. Stagger: en_in=4'b1111 in one cycle -> en_out steps 0001, 0011, 0111, 1111 with grant edges 8 cycles apart; en_all_active rises 1 cycle after the 4th grant; busy drops 8 cycles after the last grant.
3. Disable during GAP:
   - Setup: en_in=1111, then clear en_in[2] before its grant.
   - Response: channel 2 is never granted; channel 3 is granted at the 3rd grant slot.
   - Follow-up: clearing en_in[0] drops en_out[0] 3 edges later without disturbing the counter.
4. Mid-operation reset: assert rst with en_out=0011 -> en_out=0 and busy=0 asynchronously. After release with en_in held at 1111, the full stagger sequence restarts from channel 0 once rst_int has deasserted.
5. STAGGER_CYC=1: en_in=1111 -> en_out grants on 4 consecutive edges, busy stays 0.
6. Filter (FILT_CYC=3, macro defined): a 2-cycle pulse on en_in[1] -> en_out unchanged. A pulse of 4 cycles or more -> en_out[1] high 6 edges after sampling.

Source files
------------

// File: rtl/dfx_mbist_en_sync_mc.sv
// Multi-channel MBIST enable synchronizer with staggered grant sequencer.
// Optional per-channel glitch filter: define DFX_MBIST_EN_SYNC_FILTER_EN.

module dfx_mbist_en_sync_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en_in,
  output logic en_eff
);
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], en_in};

`ifdef DFX_MBIST_EN_SYNC_FILTER_EN
  localparam int FW = $clog2(FILT_CYC + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILT_CYC - 1);

  logic          filt;
  logic [FW-1:0] cnt;

  // Flip only after FILT_CYC consecutive mismatching samples; any match restarts.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (sync_q[SYNC_STAGES-1] != filt) begin
      if (cnt == F_LAST) begin
        filt <= sync_q[SYNC_STAGES-1];
        cnt  <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end

  assign en_eff = filt;
`else
  assign en_eff = sync_q[SYNC_STAGES-1];
`endif
endmodule

module dfx_mbist_en_sync_mc #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STAGGER_CYC = 8,
  parameter int FILT_CYC    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_in,
  output logic [NUM_CH-1:0] en_out,
  output logic              busy,
  output logic              en_all_active
);
  localparam int CW = $clog2(STAGGER_CYC + 1);
  localparam logic [CW-1:0] LOAD = CW'(STAGGER_CYC - 1);

  if (NUM_CH < 1 || NUM_CH > 32 || SYNC_STAGES < 2 || STAGGER_CYC < 1 || FILT_CYC < 1) begin : g_param_err
    $error("dfx_mbist_en_sync_mc: parameter out of range");
  end

  // Release chain: async set into reset, ones shift in to deassert.
  logic [SYNC_STAGES-1:0] rst_chain;
  logic                   rst_int;

  always_ff @(posedge clk or posedge rst)
    if (rst) rst_chain <= '0;
    else     rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};

  assign rst_int = ~rst_chain[SYNC_STAGES-1];

  logic [NUM_CH-1:0] en_eff;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dfx_mbist_en_sync_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYC    (FILT_CYC)
    ) u_ch (
      .clk    (clk),
      .rst    (rst_int),
      .en_in  (en_in[i]),
      .en_eff (en_eff[i])
    );
  end

  typedef enum logic {IDLE, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [NUM_CH-1:0] pending, grant, kept;

  assign pending = en_eff & ~en_out;
  assign kept    = en_out & en_eff;

  // Descending scan so the lowest-index pending bit wins.
  always_comb begin
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pending[i]) grant = NUM_CH'(1) << i;
  end

  always_ff @(posedge clk or posedge rst_int)
    if (rst_int) begin
      state         <= IDLE;
      cnt           <= '0;
      en_out        <= '0;
      busy          <= 1'b0;
      en_all_active <= 1'b0;
    end else begin
      en_all_active <= &en_out;
      case (state)
        IDLE: begin
          if (|pending) begin
            en_out <= kept | grant;
            if (STAGGER_CYC > 1) begin
              cnt   <= LOAD;
              state <= GAP;
              busy  <= 1'b1;
            end
          end else begin
            en_out <= kept;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            en_out <= kept;
          end else if (|pending) begin
            en_out <= kept | grant;
            cnt    <= LOAD;
          end else begin
            en_out <= kept;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_dfx_mbist_en_sync_mc.sv
// Directed bench for dfx_mbist_en_sync_mc: scoreboard of per-cycle expected outputs.

module tb_dfx_mbist_en_sync_mc;
  localparam int N = 4;
`ifdef DFX_MBIST_EN_SYNC_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en_a = '0, en_b = '0;
  logic [N-1:0] eo_a, eo_b;
  logic         busy_a, busy_b, all_a, all_b;

  always #5 clk = ~clk;

  dfx_mbist_en_sync_mc #(.NUM_CH(N), .SYNC_STAGES(2), .STAGGER_CYC(8), .FILT_CYC(3)) dut (
    .clk(clk), .rst(rst), .en_in(en_a), .en_out(eo_a), .busy(busy_a), .en_all_active(all_a));

  dfx_mbist_en_sync_mc #(.NUM_CH(N), .SYNC_STAGES(2), .STAGGER_CYC(1), .FILT_CYC(3)) dut_s1 (
    .clk(clk), .rst(rst), .en_in(en_b), .en_out(eo_b), .busy(busy_b), .en_all_active(all_b));

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int           cyc;
    int           unit;
    logic [N-1:0] eo;
    logic         b;
    logic         a;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_at(int c, int unit, logic [N-1:0] eo, logic b, logic a);
    exp_t e;
    e.cyc = c; e.unit = unit; e.eo = eo; e.b = b; e.a = a;
    q.push_back(e);
  endtask

  task automatic wait_to(int c);
    while (cycle < c) @(negedge clk);
  endtask

  // Scoreboard: compare every entry scheduled for this cycle.
  always @(negedge clk) begin : sb
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      e = q.pop_front();
      chk($sformatf("u%0d c%0d sched", e.unit, e.cyc), 32'(cycle), 32'(e.cyc));
      if (e.unit == 0) begin
        chk($sformatf("u0 c%0d en_out", e.cyc), 32'(eo_a), 32'(e.eo));
        chk($sformatf("u0 c%0d busy", e.cyc), 32'(busy_a), 32'(e.b));
        chk($sformatf("u0 c%0d all", e.cyc), 32'(all_a), 32'(e.a));
      end else begin
        chk($sformatf("u1 c%0d en_out", e.cyc), 32'(eo_b), 32'(e.eo));
        chk($sformatf("u1 c%0d busy", e.cyc), 32'(busy_b), 32'(e.b));
        chk($sformatf("u1 c%0d all", e.cyc), 32'(all_b), 32'(e.a));
      end
    end
  end

  initial begin
    int n, g, h, u;
    @(negedge clk);
    chk("rst en_out", 32'(eo_a), 32'h0);
    chk("rst busy", 32'(busy_a), 32'h0);
    chk("rst all", 32'(all_a), 32'h0);
    chk("rst s1 en_out", 32'(eo_b), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = cycle;
    wait_to(n + 4);

    // 1: single channel latency and gap length
    n = cycle; en_a = 4'b0001;
    expect_at(n + LAT - 1, 0, 4'b0000, 0, 0);
    expect_at(n + LAT,     0, 4'b0001, 1, 0);
    expect_at(n + LAT + 7, 0, 4'b0001, 1, 0);
    expect_at(n + LAT + 8, 0, 4'b0001, 0, 0);
    wait_to(n + LAT + 10);
    n = cycle; en_a = 4'b0000;
    expect_at(n + LAT - 1, 0, 4'b0001, 0, 0);
    expect_at(n + LAT,     0, 4'b0000, 0, 0);
    wait_to(n + LAT + 3);

    // 2: full stagger
    n = cycle; en_a = 4'b1111; g = n + LAT;
    expect_at(g,      0, 4'b0001, 1, 0);
    expect_at(g + 7,  0, 4'b0001, 1, 0);
    expect_at(g + 8,  0, 4'b0011, 1, 0);
    expect_at(g + 15, 0, 4'b0011, 1, 0);
    expect_at(g + 16, 0, 4'b0111, 1, 0);
    expect_at(g + 23, 0, 4'b0111, 1, 0);
    expect_at(g + 24, 0, 4'b1111, 1, 0);
    expect_at(g + 25, 0, 4'b1111, 1, 1);
    expect_at(g + 31, 0, 4'b1111, 1, 1);
    expect_at(g + 32, 0, 4'b1111, 0, 1);
    wait_to(g + 34);
    n = cycle; en_a = 4'b0000;
    expect_at(n + LAT,     0, 4'b0000, 0, 1);
    expect_at(n + LAT + 1, 0, 4'b0000, 0, 0);
    wait_to(n + LAT + 3);

    // 3: disable during gap
    n = cycle; en_a = 4'b1111; g = n + LAT;
    expect_at(g,     0, 4'b0001, 1, 0);
    expect_at(g + 8, 0, 4'b0011, 1, 0);
    wait_to(g + 9);
    en_a = 4'b1011;
    expect_at(g + 15, 0, 4'b0011, 1, 0);
    expect_at(g + 16, 0, 4'b1011, 1, 0);
    wait_to(g + 17);
    h = cycle; en_a = 4'b1010;
    expect_at(h + LAT - 1, 0, 4'b1011, 1, 0);
    expect_at(h + LAT,     0, 4'b1010, 1, 0);
    expect_at(g + 23,      0, 4'b1010, 1, 0);
    expect_at(g + 24,      0, 4'b1010, 0, 0);
    expect_at(g + 26,      0, 4'b1010, 0, 0);
    wait_to(g + 27);

    // 4: mid-operation reset
    n = cycle; en_a = 4'b0000;
    expect_at(n + LAT, 0, 4'b0000, 0, 0);
    wait_to(n + LAT + 2);
    n = cycle; en_a = 4'b1111; g = n + LAT;
    expect_at(g,     0, 4'b0001, 1, 0);
    expect_at(g + 8, 0, 4'b0011, 1, 0);
    wait_to(g + 10);
    rst = 1'b1;
    #1;
    chk("async rst en_out", 32'(eo_a), 32'h0);
    chk("async rst busy", 32'(busy_a), 32'h0);
    chk("async rst all", 32'(all_a), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; u = cycle;
    expect_at(u + LAT + 1,  0, 4'b0000, 0, 0);
    expect_at(u + LAT + 2,  0, 4'b0001, 1, 0);
    expect_at(u + LAT + 10, 0, 4'b0011, 1, 0);
    expect_at(u + LAT + 18, 0, 4'b0111, 1, 0);
    expect_at(u + LAT + 26, 0, 4'b1111, 1, 0);
    expect_at(u + LAT + 27, 0, 4'b1111, 1, 1);
    wait_to(u + LAT + 36);
    n = cycle; en_a = 4'b0000;
    expect_at(n + LAT, 0, 4'b0000, 0, 1);
    wait_to(n + LAT + 3);

    // 5: STAGGER_CYC == 1 grants back to back
    n = cycle; en_b = 4'b1111;
    expect_at(n + LAT - 1, 1, 4'b0000, 0, 0);
    expect_at(n + LAT,     1, 4'b0001, 0, 0);
    expect_at(n + LAT + 1, 1, 4'b0011, 0, 0);
    expect_at(n + LAT + 2, 1, 4'b0111, 0, 0);
    expect_at(n + LAT + 3, 1, 4'b1111, 0, 0);
    expect_at(n + LAT + 4, 1, 4'b1111, 0, 1);
    wait_to(n + LAT + 6);

`ifdef DFX_MBIST_EN_SYNC_FILTER_EN
    // 6: glitch filter
    n = cycle; en_a = 4'b0010;
    wait_to(n + 2);
    en_a = 4'b0000;
    expect_at(n + 8,  0, 4'b0000, 0, 0);
    expect_at(n + 12, 0, 4'b0000, 0, 0);
    wait_to(n + 14);
    n = cycle; en_a = 4'b0010;
    expect_at(n + 5, 0, 4'b0000, 0, 0);
    expect_at(n + 6, 0, 4'b0010, 1, 0);
    wait_to(n + 4);
    en_a = 4'b0000;
    expect_at(n + 9,  0, 4'b0010, 1, 0);
    expect_at(n + 10, 0, 4'b0000, 1, 0);
    expect_at(n + 14, 0, 4'b0000, 0, 0);
    wait_to(n + 16);
`endif

    wait_to(cycle + 2);
    chk("scoreboard drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
